// File: rtl/dadda_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dadda_mult_share_arbiter
// Purpose  : Round-robin arbiter that shares one combinational 8x8 Dadda
//            multiplier among N_REQ requesters. Operands are registered and
//            the 16-bit product is returned with the requester ID over a
//            valid/ready response channel.
// Options  : MULT_SHARE_PERF_EN adds a saturating 16-bit response counter
//            on output port perf_ops.
// Revision : 1.0  initial release
// ============================================================================

// Unsigned 8x8 -> 16 multiplier. Eight shifted partial-product rows are
// compressed with 3:2 carry-save stages following the Dadda height sequence
// 8 -> 6 -> 4 -> 3 -> 2, then a single carry-propagate add produces the result.
// All rows are 16 bits wide; the true product never exceeds 16 bits, so the
// modulo-2^16 carry-save arithmetic is exact.
module dadda_multiplier_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] pp [8];

  // Partial products: row j is A gated by B[j], shifted left by j
  for (genvar j = 0; j < 8; j++) begin : g_pp
    assign pp[j] = b[j] ? ({8'h00, a} << j) : 16'h0000;
  end

  // 3:2 compressor applied bitwise to three 16-bit rows
  function automatic logic [31:0] csa(input logic [15:0] x,
                                      input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s;
    logic [15:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [31:0] l1_0, l1_1;        // 8 rows -> 6 rows
  logic [31:0] l2_0, l2_1;        // 6 rows -> 4 rows
  logic [31:0] l3_0;              // 4 rows -> 3 rows
  logic [31:0] l4_0;              // 3 rows -> 2 rows

  assign l1_0 = csa(pp[0], pp[1], pp[2]);
  assign l1_1 = csa(pp[3], pp[4], pp[5]);

  assign l2_0 = csa(l1_0[15:0], l1_0[31:16], l1_1[15:0]);
  assign l2_1 = csa(l1_1[31:16], pp[6], pp[7]);

  assign l3_0 = csa(l2_0[15:0], l2_0[31:16], l2_1[15:0]);

  assign l4_0 = csa(l3_0[15:0], l3_0[31:16], l2_1[31:16]);

  assign p = l4_0[15:0] + l4_0[31:16];

endmodule

module dadda_mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_product,
  output logic                 busy
`ifdef MULT_SHARE_PERF_EN
  ,
  output logic [15:0]          perf_ops
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            any_valid;
  logic            accept;
  logic [7:0]      op_a, op_b;
  logic [ID_W-1:0] op_id;
  logic [15:0]     mult_p;

  // Round-robin search: lowest offset from rr_ptr with req_valid set wins,
  // so the loop runs from the farthest offset down and the nearest overwrites.
  always_comb begin
    any_valid = |req_valid;
    grant     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_ptr) + i) % N_REQ])
        grant = ID_W'((int'(rr_ptr) + i) % N_REQ);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and grant decode
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          req_ready  = N_REQ'(1) << grant;
          accept     = 1'b1;
          next_state = S_EXEC;
        end
      end
      S_EXEC:  next_state = S_RESP;
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Operand capture, pointer advance and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (accept) begin
        op_a   <= req_a[8*grant +: 8];
        op_b   <= req_b[8*grant +: 8];
        op_id  <= grant;
        rr_ptr <= ID_W'((int'(grant) + 1) % N_REQ);
      end
      if (state == S_EXEC) begin
        rsp_product <= mult_p;
        rsp_id      <= op_id;
        rsp_valid   <= 1'b1;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid   <= 1'b0;
      end
    end
  end

  dadda_multiplier_8x8 u_mult (
    .a (op_a),
    .b (op_b),
    .p (mult_p)
  );

`ifdef MULT_SHARE_PERF_EN
  // Saturating count of completed response handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_ops <= '0;
    else if (rsp_valid && rsp_ready && perf_ops != 16'hFFFF)
      perf_ops <= perf_ops + 16'd1;
  end
`endif

endmodule
`default_nettype wire
